dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder that answers the load/store requests issued by the MEM stage of the 5-stage MIPS pipeline. It accepts the MEM stage's read/write enables, byte address (ALU result) and store value, holds the pipeline through a `freeze` output while a configurable number of wait states elapse, then completes the access against an internal word array. It replaces the single-cycle data memory and sits between the EXE/MEM register and the MEM/WB register, with `freeze` routed to the hazard/stall logic.

## Interface
- `BASE_ADDR`, 1024: byte address mapped to word 0.
- `DEPTH`, 64: number of 32-bit words; a power of two.
- `WAIT_CYCLES`, 5: BUSY cycles per access; legal range 1..15.
- `clk` input 1: the only clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `MEM_R_EN` input 1: load request.
- `MEM_W_EN` input 1: store request.
- `ALU_result` input 32: byte address.
- `ST_val` input 32: store data.
- `MEM_read_value` output 32: load data; valid in DONE.
- `ready` output 1: access complete this cycle.
- `freeze` output 1: stall the pipeline (request pending, not ready).
- `err` output 1: access fault (only with `DMEM_ERR_EN`, else tied 0).

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state IDLE.
- IDLE, no request: `ready`=1, `freeze`=0.
- IDLE, request (`MEM_R_EN|MEM_W_EN`):
  - latch address, data and op;
  - load counter with `WAIT_CYCLES-1`;
  - go BUSY;
  - `ready`=0 and `freeze`=1, combinationally, in this same cycle.
- BUSY: `freeze`=1, `ready`=0.
  - Counter nonzero: decrement.
  - Counter zero: perform the access (array write, or latch the array word into `MEM_read_value`), go DONE.
- DONE: `ready`=1, `freeze`=0 for exactly one cycle; go IDLE unconditionally. A request still asserted in DONE belongs to the retiring instruction and is ignored. A request seen in the following IDLE cycle is a new access.
- Word index = `(ALU_result - BASE_ADDR) >> 2`, truncated to log2(DEPTH) bits; byte offset bits ignored.
- Both enables high: treated as a store.
- Requester holds enables, address and data stable until `ready`. The block uses only the values latched in IDLE.
- `MEM_read_value` holds its last load result until the next load completes; stores do not change it.

## Timing
- Reset values: state IDLE, counter 0, `MEM_read_value`=0, `ready`=1, `freeze`=0, `err`=0. The array is not cleared.
- Access latency: request accepted in cycle N; DONE in cycle N+WAIT_CYCLES+1. `freeze` is high for cycles N..N+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles.
- The array write takes effect at the BUSY→DONE edge. A load issued in the IDLE cycle right after a store's DONE returns the new data.
- Back-to-back accesses: minimum spacing is WAIT_CYCLES+2 cycles (the DONE cycle plus a fresh IDLE acceptance).
- Reset mid-BUSY: the access is abandoned. A pending store is not written. Outputs return to their reset values on the next edge.

## Configuration
- `DMEM_ERR_EN` defined: a fault is an address below `BASE_ADDR`, an index ≥ DEPTH before truncation, or `ALU_result[1:0]`≠0.
  - Fault detected on the latched address.
  - `err`=1 only in the DONE cycle.
  - A faulting store is suppressed.
  - A faulting load returns 0.
- `DMEM_ERR_EN` undefined: no checks, `err` tied to 0, index wraps modulo DEPTH.

## Structure
- Shared package `mips_pkg`: FSM state enum (`DMEM_IDLE`, `DMEM_BUSY`, `DMEM_DONE`), the default `BASE_ADDR`, and the 32-bit word type.
- One sub-module, `dmem_array`: a DEPTH×32 synchronous-write, asynchronous-read array with ports `clk`, `we`, `addr`, `wdata`, `rdata`.
- FSM, counter and fault check stay in the top level.

## Test plan
- Reset, then IDLE with no request → `ready`=1, `freeze`=0, `MEM_read_value`=0, `err`=0.
- Store 0xDEADBEEF to 1028 with WAIT_CYCLES=5 → `freeze` high for 6 cycles, `ready` pulses one cycle; a following load from 1028 returns 0xDEADBEEF after 6 freeze cycles.
- Both enables high, address 1032, `ST_val`=0x12345678 → treated as a store; a load from 1032 returns 0x12345678; `MEM_read_value` unchanged during the store.
- Assert `rst` in the 3rd BUSY cycle of a store of 0xA5A5A5A5 to 1036 → FSM returns to IDLE, outputs reset; a load from 1036 returns the prior contents.
- With `DMEM_ERR_EN`, load from 1030 (misaligned) and from 1020 (below base) → `err`=1 in DONE, data 0; a store to 1024+4·DEPTH is suppressed, and word 0 is unchanged.
- Without `DMEM_ERR_EN`, store 0x55 to 1024+4·DEPTH → word 0 reads back 0x55, `err` stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the data-memory responder:
// responder FSM states, the default data-segment base address and the
// 32-bit word type.
package mips_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

    localparam word_t DMEM_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage for the data-memory responder.
// Synchronous write, asynchronous read, no reset: contents survive rst.
module dmem_array
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  word_t         wdata,
    output word_t         rdata
);

    word_t mem_q [DEPTH];

    // Write port: one word per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
// A load/store accepted in IDLE freezes the pipeline for WAIT_CYCLES BUSY
// cycles, completes against dmem_array on the last BUSY edge and signals
// ready for one DONE cycle.
// Optional macro DMEM_ERR_EN: enables address fault checks and the err
// output; when undefined err is tied low and the word index wraps.
//
// state     | meaning
// DMEM_IDLE | no access in flight; a request is accepted here
// DMEM_BUSY | wait states counting down; access performed when count is 0
// DMEM_DONE | access complete, ready for exactly one cycle
module dmem_responder
    import mips_pkg::*;
#(
    parameter word_t       BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ST_val,
    output logic [31:0] MEM_read_value,
    output logic        ready,
    output logic        freeze,
    output logic        err
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    word_t       addr_q, addr_d;
    word_t       wdata_q, wdata_d;
    logic        wr_q, wr_d;
    word_t       rdata_q, rdata_d;
    logic        err_q, err_d;

    logic          req;
    word_t         off;
    logic [AW-1:0] idx;
    logic          fault;
    logic          arr_we;
    word_t         arr_rdata;
    logic          unused_off;

    assign req = MEM_R_EN | MEM_W_EN;
    assign off = addr_q - BASE_ADDR;
    assign idx = off[AW+1:2];
    // Only the index bits select a word; the rest feed the fault check.
    assign unused_off = ^{off[31:AW+2], off[1:0]};

`ifdef DMEM_ERR_EN
    // Out-of-window, beyond-depth (before truncation) or misaligned address.
    assign fault = (addr_q < BASE_ADDR) || (off[31:AW+2] != '0) || (addr_q[1:0] != 2'b00);
`else
    assign fault = 1'b0;
`endif

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (idx),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // Next-state, handshake outputs and access strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        arr_we  = 1'b0;
        ready   = 1'b0;
        freeze  = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                ready  = ~req;
                freeze = req;
                if (req) begin
                    addr_d  = ALU_result;
                    wdata_d = ST_val;
                    wr_d    = MEM_W_EN;
                    cnt_d   = CNT_LOAD;
                    err_d   = 1'b0;
                    state_d = DMEM_BUSY;
                end
            end
            DMEM_BUSY: begin
                freeze = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DMEM_DONE;
                    err_d   = fault;
                    if (wr_q) begin
                        arr_we = ~fault;
                    end else begin
                        rdata_d = fault ? '0 : arr_rdata;
                    end
                end
            end
            DMEM_DONE: begin
                // A request still held here belongs to the retiring access.
                ready   = 1'b1;
                state_d = DMEM_IDLE;
            end
            default: begin
                state_d = DMEM_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign MEM_read_value = rdata_q;
    assign err            = (state_q == DMEM_DONE) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (default parameters: base 1024,
// depth 64, 5 wait cycles). Driver pushes expected completions; the
// monitor pops one at every ready that follows a frozen cycle.
module tb_dmem_responder;

    localparam int WAITC = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MEM_R_EN = 1'b0;
    logic        MEM_W_EN = 1'b0;
    logic [31:0] ALU_result = '0;
    logic [31:0] ST_val = '0;
    logic [31:0] MEM_read_value;
    logic        ready;
    logic        freeze;
    logic        err;

    dmem_responder dut (
        .clk            (clk),
        .rst            (rst),
        .MEM_R_EN       (MEM_R_EN),
        .MEM_W_EN       (MEM_W_EN),
        .ALU_result     (ALU_result),
        .ST_val         (ST_val),
        .MEM_read_value (MEM_read_value),
        .ready          (ready),
        .freeze         (freeze),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          frz;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: counts frozen cycles and checks each completion.
    logic prev_frz = 1'b0;
    int   frz_cnt  = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_frz = 1'b0;
            frz_cnt  = 0;
        end else begin
            if (freeze) frz_cnt++;
            if (ready && prev_frz) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL unexpected_done: got completion expected none");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("v%0d_rdata", e.tag), MEM_read_value, e.rd);
                    chk($sformatf("v%0d_err", e.tag), {31'd0, err}, {31'd0, e.er});
                    chk($sformatf("v%0d_freeze_len", e.tag), frz_cnt, e.frz);
                end
                frz_cnt = 0;
            end
            prev_frz = freeze;
        end
    end

    // Called at posedge+1 with the responder in IDLE; returns at posedge+1
    // in the IDLE cycle following DONE, enables dropped.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd,
                          input logic exp_er, input int tag);
        exp_t e;
        bit seen = 0;
        bit done = 0;
        e.rd = exp_rd; e.er = exp_er; e.frz = WAITC + 1; e.tag = tag;
        exp_q.push_back(e);
        MEM_R_EN = r; MEM_W_EN = w; ALU_result = a; ST_val = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (freeze) seen = 1;
            else if (seen && ready) done = 1;
        end
        if (!done) begin
            n_vec++;
            n_mis++;
            $display("FAIL v%0d_timeout: got no ready expected ready within 40 cycles", tag);
        end
        @(posedge clk); #1;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_freeze", {31'd0, freeze}, 32'd0);
        chk("reset_rdata", MEM_read_value, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;

        access(0, 1, 32'd1028, 32'hDEADBEEF, 32'h0, 0, 1);
        access(1, 0, 32'd1028, 32'h0,        32'hDEADBEEF, 0, 2);
        access(1, 1, 32'd1032, 32'h12345678, 32'hDEADBEEF, 0, 3);
        access(1, 0, 32'd1032, 32'h0,        32'h12345678, 0, 4);
        access(0, 1, 32'd1036, 32'h0BADF00D, 32'h12345678, 0, 5);

        // Store to 1036 abandoned by reset in its third BUSY cycle.
        MEM_W_EN = 1'b1; ALU_result = 32'd1036; ST_val = 32'hA5A5A5A5;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; MEM_W_EN = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_freeze", {31'd0, freeze}, 32'd0);
        chk("abort_rdata", MEM_read_value, 32'd0);
        chk("abort_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;

        access(1, 0, 32'd1036, 32'h0,        32'h0BADF00D, 0, 6);
        access(0, 1, 32'd1024, 32'h11112222, 32'h0BADF00D, 0, 7);
`ifdef DMEM_ERR_EN
        access(1, 0, 32'd1030, 32'h0,  32'h0, 1, 8);
        access(1, 0, 32'd1020, 32'h0,  32'h0, 1, 9);
        access(0, 1, 32'd1280, 32'h55, 32'h0, 1, 10);
        access(1, 0, 32'd1024, 32'h0,  32'h11112222, 0, 11);
`else
        access(0, 1, 32'd1280, 32'h55, 32'h0BADF00D, 0, 8);
        access(1, 0, 32'd1024, 32'h0,  32'h00000055, 0, 9);
        access(1, 0, 32'd1028, 32'h0,  32'hDEADBEEF, 0, 10);
`endif
        repeat (2) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
